fetch_stage: RTL and testbench

Instruction-fetch stage of the single-issue RISC-V core. It owns the program counter and drives it to the combinational instruction memory, which returns the word at `pc>>2` in the same cycle. It captures the returned word into the IF/ID pipeline register. It also handles stall, flush and branch/jump redirect from later stages, plus a halt word that freezes fetch.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/if_id_reg.sv | 52 +++++
 rtl/fetch_stage.sv | 125 ++++++++++++
 tb/tb_fetch_stage.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core: datapath width, the canonical
// bubble word and the fetch-stage state encoding.
package riscv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSN_C = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] i_addr);
        return i_addr & ~{{(XLEN-2){1'b0}}, 2'b11};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds valid/pc/pc_plus4/instr. Each edge either
// loads a fetched word, loads a bubble (valid dropped, NOP word, PCs kept),
// or holds. Bubble wins if both controls are raised.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSN = NOP_INSN_C
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_bubble,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_instr,
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_plus4,
    output logic [XLEN-1:0] o_instr
);

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc_plus4;
    logic [XLEN-1:0] r_instr;

    // Register set update: reset, bubble, load, otherwise hold.
    always_ff @(posedge clk) begin
        // NOTE: every register here is a plain flop, so all of them get a
        // reset value; sequential state is always written with <= so that
        // all flops sample pre-edge values regardless of statement order.
        if (rst) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_pc_plus4 <= XLEN'(4);
            r_instr    <= NOP_INSN;
        end else if (i_bubble) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSN;
        end else if (i_load) begin
            r_valid    <= 1'b1;
            r_pc       <= i_pc;
            r_pc_plus4 <= i_pc + XLEN'(4);
            r_instr    <= i_instr;
        end
    end

    assign o_valid    = r_valid;
    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_instr    = r_instr;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction
// memory, and fills the IF/ID register. Handles stall, flush, redirect from
// later stages, and freezes fetch when the halt word is captured.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] HALT_INSN = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSN  = NOP_INSN_C
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] instruction,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc_plus4,
    output logic [XLEN-1:0] if_id_instr,
    output logic            halted,
    output logic [XLEN-1:0] fetch_count
);

    fetch_state_t    r_state;
    fetch_state_t    w_next_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_next_pc;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_redirect_target;
    logic            r_halted;
    logic [XLEN-1:0] r_fetch_count;
    logic            w_load;
    logic            w_bubble;

    assign w_pc_plus4        = r_pc + XLEN'(4);
    assign w_redirect_target = word_align(redirect_pc);

    // Next-state, next-PC and IF/ID control. Redirect outranks stall; a
    // flush turns whatever the IF/ID register would do into a bubble.
    always_comb begin
        // NOTE: defaults first, so every path assigns every output and no
        // latch is inferred.
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_load       = 1'b0;
        w_bubble     = 1'b0;
        case (r_state)
            BOOT: begin
                // Memory gets one quiet cycle after reset release.
                w_next_state = RUN;
            end
            RUN: begin
                if (redirect_valid) begin
                    w_next_pc = w_redirect_target;
                    w_bubble  = 1'b1;
                end else if (stall) begin
                    w_bubble = flush;
                end else if (flush) begin
                    w_bubble  = 1'b1;
                    w_next_pc = w_pc_plus4;
                end else begin
                    w_load = 1'b1;
                    if (instruction == HALT_INSN) begin
                        w_next_state = HALT;
                    end else begin
                        w_next_pc = w_pc_plus4;
                    end
                end
            end
            HALT: begin
                // A redirect means the halt was on a wrong path.
                if (redirect_valid) begin
                    w_next_pc    = w_redirect_target;
                    w_bubble     = 1'b1;
                    w_next_state = RUN;
                end else if (!stall) begin
                    w_bubble = 1'b1;
                end
            end
            default: begin
                w_next_state = BOOT;
            end
        endcase
    end

    // State, PC, halt flag and delivered-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= BOOT;
            r_pc          <= RESET_PC;
            r_halted      <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            r_state  <= w_next_state;
            r_pc     <= w_next_pc;
            r_halted <= (w_next_state == HALT);
            if (w_load) begin
                r_fetch_count <= r_fetch_count + XLEN'(1);
            end
        end
    end

    if_id_reg #(
        .NOP_INSN (NOP_INSN)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_bubble   (w_bubble),
        .i_pc       (r_pc),
        .i_instr    (instruction),
        .o_valid    (if_id_valid),
        .o_pc       (if_id_pc),
        .o_pc_plus4 (if_id_pc_plus4),
        .o_instr    (if_id_instr)
    );

    assign pc          = r_pc;
    assign halted      = r_halted;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a small instruction memory model,
// directed stimulus and a scoreboard of expected IF/ID captures.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
    logic        halted;
    logic [31:0] fetch_count;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
    } cap_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] mem [0:63];
    cap_t        sb[$];
    cap_t        last;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_count;
    logic [31:0] prev_count;

    always #5 clk = ~clk;

    assign instruction = mem[pc[7:2]];

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (pc),
        .instruction    (instruction),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_instr    (if_id_instr),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expect a capture of the word at pc_val on the coming edge.
    task automatic expect_capture(input logic [31:0] pc_val);
        cap_t c;
        c.pc       = pc_val;
        c.pc_plus4 = pc_val + 32'd4;
        c.instr    = mem[pc_val[7:2]];
        sb.push_back(c);
        exp_count = exp_count + 32'd1;
    endtask

    task automatic expect_reset();
        sb.delete();
        exp_count = 32'd0;
        last      = '{pc: 32'd0, pc_plus4: 32'd4, instr: NOP};
    endtask

    // One edge, then check outputs #1 later.
    task automatic tick(input logic [31:0] e_pc, input logic e_valid, input logic e_halted);
        @(posedge clk);
        #1;
        chk("pc", pc, e_pc);
        chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, e_valid});
        chk("halted", {31'd0, halted}, {31'd0, e_halted});
        chk("fetch_count", fetch_count, exp_count);
        if (if_id_valid && fetch_count != prev_count) begin
            chk("sb_has_entry", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) last = sb.pop_front();
        end
        if (e_valid) begin
            chk("if_id_pc", if_id_pc, last.pc);
            chk("if_id_pc_plus4", if_id_pc_plus4, last.pc_plus4);
            chk("if_id_instr", if_id_instr, last.instr);
        end else begin
            chk("bubble_instr", if_id_instr, NOP);
            chk("bubble_pc_hold", if_id_pc, last.pc);
            chk("bubble_pc4_hold", if_id_pc_plus4, last.pc_plus4);
        end
        prev_count = fetch_count;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000 + 32'(i);
        mem[0]  = 32'h11;
        mem[1]  = 32'h22;
        mem[2]  = 32'h33;
        mem[3]  = 32'h0;      // halt word at 0x0C
        mem[16] = 32'h55;     // 0x40
        mem[63] = 32'h77;     // 0xFFFF_FFFC
        prev_count     = 32'd0;
        rst            = 1'b1;
        stall          = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;

        // Reset values.
        expect_reset();
        tick(32'h0, 1'b0, 1'b0);

        // BOOT cycle, then sequential fetch.
        rst = 1'b0;
        tick(32'h0, 1'b0, 1'b0);
        expect_capture(32'h0); tick(32'h4, 1'b1, 1'b0);
        expect_capture(32'h4); tick(32'h8, 1'b1, 1'b0);

        // Stall for three cycles at pc=8.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) tick(32'h8, 1'b1, 1'b0);
        stall = 1'b0;
        expect_capture(32'h8); tick(32'hC, 1'b1, 1'b0);

        // Redirect with stall, unaligned target.
        redirect_valid = 1'b1; redirect_pc = 32'h42; stall = 1'b1;
        tick(32'h40, 1'b0, 1'b0);
        redirect_valid = 1'b0; stall = 1'b0;
        expect_capture(32'h40); tick(32'h44, 1'b1, 1'b0);

        // Flush alone: bubble while pc advances.
        flush = 1'b1;
        tick(32'h48, 1'b0, 1'b0);
        flush = 1'b0;
        expect_capture(32'h48); tick(32'h4C, 1'b1, 1'b0);

        // Flush under stall: pc holds, IF/ID cleared.
        stall = 1'b1; flush = 1'b1;
        tick(32'h4C, 1'b0, 1'b0);
        stall = 1'b0; flush = 1'b0;

        // Halt: go to 0x0C, capture the halt word, then bubbles.
        redirect_valid = 1'b1; redirect_pc = 32'hC;
        tick(32'hC, 1'b0, 1'b0);
        redirect_valid = 1'b0;
        expect_capture(32'hC); tick(32'hC, 1'b1, 1'b1);
        tick(32'hC, 1'b0, 1'b1);
        stall = 1'b1;
        tick(32'hC, 1'b0, 1'b1);
        stall = 1'b0;
        tick(32'hC, 1'b0, 1'b1);

        // Release halt with a redirect to 0.
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        tick(32'h0, 1'b0, 1'b0);
        redirect_valid = 1'b0;
        expect_capture(32'h0); tick(32'h4, 1'b1, 1'b0);

        // Wrap-around at the top of the address space.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick(32'hFFFF_FFFC, 1'b0, 1'b0);
        redirect_valid = 1'b0;
        expect_capture(32'hFFFF_FFFC); tick(32'h0, 1'b1, 1'b0);

        // Reset beats a simultaneous redirect.
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
        expect_reset();
        tick(32'h0, 1'b0, 1'b0);
        rst = 1'b0; redirect_valid = 1'b0;
        tick(32'h0, 1'b0, 1'b0);
        expect_capture(32'h0); tick(32'h4, 1'b1, 1'b0);

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
